imem_responder: RTL

Instruction-memory responder for the RV32 pipeline: the memory-side end of the fetch interface. Accepts word-aligned fetch addresses from the fetch stage, returns the 32-bit instruction after a configurable number of wait states with a one-cycle valid pulse, and drives a busy/stall indication back to the front end. Honours a flush from branch resolution, flags misaligned and out-of-range fetches, and exposes a write port for program loading.

---
 rtl/imem_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the RV32 fetch interface.
// Define IMEM_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        instr_err_o,
  output logic        busy_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          pend;
  logic [AW-1:0] idx_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] req_idx;
  logic          req_bad;
  logic          accept;
  logic          hit;
  logic [AW-1:0] wr_idx;
  logic          wr_ok;
  logic [31:0]   rd_data;

  assign req_idx = instr_addr_i[AW+1:2];
  assign req_bad = (instr_addr_i[1:0] != 2'b00) ||
                   (instr_addr_i[31:AW+2] != '0);
  assign accept  = instr_req_i &&
                   (state == S_IDLE || flush_i);
  assign wr_idx  = wr_addr_i[AW+1:2];
  assign wr_ok   = wr_en_i && (wr_addr_i[31:AW+2] == '0);
  assign busy_o  = (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data_i;
  end

`ifdef IMEM_PREFETCH_EN
  logic [AW-1:0] ptag;
  logic [31:0]   pdata;
  logic          pvalid;
  logic          hit_q;
  logic [31:0]   hdata_q;
  logic          fill;
  logic [AW-1:0] fill_idx;

  assign hit = pvalid && !req_bad && !flush_i &&
               state == S_IDLE && req_idx == ptag;
  assign fill = pend && !flush_i && !err_q &&
                idx_q != LAST;
  assign fill_idx = idx_q + 1'b1;
  assign rd_data = hit_q ? hdata_q : mem[idx_q];

  // A write landing on the word being filled leaves stale data, so drop it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptag    <= '0;
      pdata   <= '0;
      pvalid  <= 1'b0;
      hit_q   <= 1'b0;
      hdata_q <= '0;
    end else begin
      if (accept) begin
        hit_q   <= hit;
        hdata_q <= pdata;
      end
      if (fill) begin
        ptag   <= fill_idx;
        pdata  <= mem[fill_idx];
        pvalid <= !(wr_ok && wr_idx == fill_idx);
      end else if (wr_ok && wr_idx == ptag) begin
        pvalid <= 1'b0;
      end
      if (flush_i) pvalid <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
  assign rd_data = mem[idx_q];
`endif

  // pend marks "respond at the next edge"; flush kills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pend          <= 1'b0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      instr_err_o   <= 1'b0;
    end else begin
      instr_valid_o <= 1'b0;
      instr_err_o   <= 1'b0;
      pend          <= 1'b0;
      if (pend && !flush_i) begin
        instr_valid_o <= 1'b1;
        instr_err_o   <= err_q;
        instr_o       <= err_q ? NOP : rd_data;
      end
      if (flush_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end
      if (accept) begin
        idx_q <= req_idx;
        err_q <= req_bad;
        if (WAIT_STATES == 0 || hit) begin
          pend <= 1'b1;
        end else begin
          state <= S_WAIT;
          cnt   <= 4'(WAIT_STATES - 1);
        end
      end else if (state == S_WAIT && !flush_i) begin
        if (cnt == 4'd0) begin
          state <= S_IDLE;
          pend  <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule
